// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencing FSM for the RV32I datapath.
// It fetches over a req/ack port, decodes the opcode class, and then
// sequences EXEC/MEM/WB with per-state enables for PC, IR, ALU, data
// memory and register file. Each memory wait is bounded by a timeout
// that raises bus_err and retries from FETCH.
// Optional feature: define PERF_CNT_EN to add the instret counter/port.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_we,
    output logic             illegal,
    output logic             bus_err
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    // The timeout counter must hold TIMEOUT-1; a bad parameter set stops elaboration.
    if (TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
        $error("multicycle_ctrl: TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_BR} cls_t;

    state_t        state, state_nxt;
    cls_t          cls, dec_cls;
    logic          dec_legal;
    logic [TW-1:0] tmo_cnt;
    logic          waiting;
    logic          ack_in;
    logic          tmo_hit;
    logic [1:0]    cls_alu_op;
    logic          cls_alu_src;
    logic          cls_is_ld;

    // Opcode to instruction class; anything unrecognised retires as a NOP.
    always_comb begin
        dec_cls   = C_R;
        dec_legal = 1'b1;
        case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LD;
            7'b0100011: dec_cls = C_ST;
            7'b1100011: dec_cls = C_BR;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Class-derived ALU controls, held from EXEC through WB.
    always_comb begin
        cls_alu_op  = 2'b10;
        cls_alu_src = 1'b0;
        cls_is_ld   = 1'b0;
        case (cls)
            C_R:     begin cls_alu_op = 2'b10; cls_alu_src = 1'b0; end
            C_I:     begin cls_alu_op = 2'b10; cls_alu_src = 1'b1; end
            C_LD:    begin cls_alu_op = 2'b00; cls_alu_src = 1'b1; cls_is_ld = 1'b1; end
            C_ST:    begin cls_alu_op = 2'b00; cls_alu_src = 1'b1; end
            C_BR:    begin cls_alu_op = 2'b01; cls_alu_src = 1'b0; end
            default: begin cls_alu_op = 2'b10; cls_alu_src = 1'b0; end
        endcase
    end

    // Only the port the current state is waiting on can complete or time out;
    // an ack on the last allowed cycle counts as a normal completion.
    always_comb begin
        waiting = (state == S_FETCH) || (state == S_MEM);
        ack_in  = (state == S_FETCH) ? imem_ack : dmem_ack;
        tmo_hit = waiting && !ack_in && (tmo_cnt == TMO_LAST);
    end

    // State register, latched class, and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            cls     <= C_R;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                cls <= dec_cls;
            // Any entry into FETCH/MEM (including the retry self-loop) restarts the count.
            if (state_nxt != state || tmo_hit)
                tmo_cnt <= '0;
            else if (waiting)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (imem_ack)
                    state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = dec_legal ? S_EXEC : S_FETCH;
            S_EXEC: begin
                case (cls)
                    C_BR:       state_nxt = S_FETCH;
                    C_LD, C_ST: state_nxt = S_MEM;
                    default:    state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack)
                    state_nxt = (cls == C_ST) ? S_FETCH : S_WB;
                else if (tmo_hit)
                    state_nxt = S_FETCH;
            end
            S_WB:    state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs; forced to 0 while reset is asserted so an abort issues no enables.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                    bus_err  = tmo_hit;
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        illegal = 1'b1;
                        pc_we   = 1'b1;
                    end
                end
                S_EXEC: begin
                    alu_op     = cls_alu_op;
                    alu_src    = cls_alu_src;
                    mem_to_reg = cls_is_ld;
                    if (cls == C_BR) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken;
                    end
                end
                S_MEM: begin
                    alu_op     = cls_alu_op;
                    alu_src    = cls_alu_src;
                    mem_to_reg = cls_is_ld;
                    dmem_req   = 1'b1;
                    dmem_we    = (cls == C_ST);
                    pc_we      = dmem_ack && (cls == C_ST);
                    bus_err    = tmo_hit;
                end
                S_WB: begin
                    alu_op     = cls_alu_op;
                    alu_src    = cls_alu_src;
                    mem_to_reg = cls_is_ld;
                    reg_we     = 1'b1;
                    pc_we      = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Retired-instruction counter: one count per PC update, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (pc_we)
            instret <= instret + 1'b1;
    end
`endif

endmodule
